// File: rtl/scoreboard_pkg.sv
// Shared constants, state/result types and the two-digit BCD step function for the scoreboard.
package scoreboard_pkg;

  localparam logic [4:0] SEG_C     = 5'd10;
  localparam logic [4:0] SEG_P     = 5'd11;
  localparam logic [4:0] SEG_R     = 5'd12;
  localparam logic [4:0] SEG_BLANK = 5'd0;

  typedef enum logic {SCORE, MSG} sb_state_t;
  typedef enum logic [1:0] {RES_P1, RES_P2, RES_DRAW} sb_result_t;

  // cnt = {tens, ones}; clr wins over inc, 99 wraps to 00
  function automatic logic [7:0] bcd2_next(input logic [7:0] cnt, input logic inc, input logic clr);
    logic [7:0] n;
    n = cnt;
    if (clr) begin
      n = 8'h00;
    end else if (inc) begin
      if (cnt[3:0] == 4'd9) begin
        n[3:0] = 4'd0;
        n[7:4] = (cnt[7:4] == 4'd9) ? 4'd0 : cnt[7:4] + 4'd1;
      end else begin
        n[3:0] = cnt[3:0] + 4'd1;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/scoreboard_ctrl_bcd_counter2.sv
// Two-digit BCD win counter 00..99 with wrap; clr beats inc.
// Latency: 1 clk from inc/clr to tens/ones. No backpressure.
module bcd_counter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc,
  input  logic       clr,
  output logic [3:0] tens,
  output logic [3:0] ones
);
  import scoreboard_pkg::*;

  logic [7:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) r_cnt <= 8'h00;
    else        r_cnt <= bcd2_next(r_cnt, inc, clr);
  end

  assign tens = r_cnt[7:4];
  assign ones = r_cnt[3:0];

endmodule

// File: rtl/scoreboard_ctrl.sv
// Scoreboard front end for four 7-seg decoders: scores view plus timed result message.
// Latency: every output registered, 1 clk after the causing input. No backpressure.
// Optional message blinking when BLINK_EN is defined.
module scoreboard_ctrl #(
  parameter int unsigned MSG_CYCLES   = 100_000_000,
  parameter int unsigned BLINK_CYCLES = 12_500_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       win_p1,
  input  logic       win_p2,
  input  logic       draw,
  input  logic       clr_scores,
  output logic [4:0] dig3_num,
  output logic [4:0] dig2_num,
  output logic [4:0] dig1_num,
  output logic [4:0] dig0_num,
  output logic [3:0] dig_en,
  output logic       msg_active
);
  import scoreboard_pkg::*;

  localparam int TW = (MSG_CYCLES > 1) ? $clog2(MSG_CYCLES) : 1;

  logic        w_any, w_inc_p1, w_inc_p2, w_vis_nxt;
  logic [3:0]  w_p1_tens, w_p1_ones, w_p2_tens, w_p2_ones;
  logic [7:0]  w_p1_nxt, w_p2_nxt;
  sb_result_t  w_res_in, w_res_nxt, r_res;
  sb_state_t   w_state_nxt, r_state;
  logic [TW-1:0] w_hold_nxt, r_hold;
  logic [4:0]  w_d3, w_d2, w_d1, w_d0;
  logic [3:0]  w_en;
  logic [4:0]  r_d3, r_d2, r_d1, r_d0;
  logic [3:0]  r_en;
  logic        r_msg;

  assign w_any    = win_p1 | win_p2 | draw;
  assign w_inc_p1 = win_p1;
  assign w_inc_p2 = win_p2 & ~win_p1;
  assign w_res_in = win_p1 ? RES_P1 : (win_p2 ? RES_P2 : RES_DRAW);

  bcd_counter2 u_p1 (.clk(clk), .rst_n(rst_n), .inc(w_inc_p1), .clr(clr_scores),
                     .tens(w_p1_tens), .ones(w_p1_ones));
  bcd_counter2 u_p2 (.clk(clk), .rst_n(rst_n), .inc(w_inc_p2), .clr(clr_scores),
                     .tens(w_p2_tens), .ones(w_p2_ones));

  // Mirror the counters' next value so the score view lands in the same cycle as the count
  assign w_p1_nxt = bcd2_next({w_p1_tens, w_p1_ones}, w_inc_p1, clr_scores);
  assign w_p2_nxt = bcd2_next({w_p2_tens, w_p2_ones}, w_inc_p2, clr_scores);

  always_comb begin
    w_state_nxt = r_state;
    w_res_nxt   = r_res;
    w_hold_nxt  = r_hold;
    if (w_any) begin
      w_state_nxt = MSG;
      w_res_nxt   = w_res_in;
      w_hold_nxt  = '0;
    end else if (r_state == MSG) begin
      if (r_hold == TW'(MSG_CYCLES - 1)) begin
        w_state_nxt = SCORE;
        w_hold_nxt  = '0;
      end else begin
        w_hold_nxt = r_hold + 1'b1;
      end
    end
  end

`ifdef BLINK_EN
  localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  logic [BW-1:0] r_blink, w_blink_nxt;
  logic          r_vis;

  always_comb begin
    w_blink_nxt = r_blink;
    w_vis_nxt   = r_vis;
    if (w_any) begin
      w_blink_nxt = '0;
      w_vis_nxt   = 1'b1;
    end else if (r_state == MSG) begin
      if (r_blink == BW'(BLINK_CYCLES - 1)) begin
        w_blink_nxt = '0;
        w_vis_nxt   = ~r_vis;
      end else begin
        w_blink_nxt = r_blink + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_blink <= '0;
      r_vis   <= 1'b1;
    end else begin
      r_blink <= w_blink_nxt;
      r_vis   <= w_vis_nxt;
    end
  end
`else
  assign w_vis_nxt = 1'b1;
`endif

  always_comb begin
    w_d1 = SEG_BLANK;
    w_d0 = SEG_BLANK;
    if (w_state_nxt == MSG) begin
      case (w_res_nxt)
        RES_P1:  begin w_d3 = SEG_P; w_d2 = 5'd1;  end
        RES_P2:  begin w_d3 = SEG_P; w_d2 = 5'd2;  end
        default: begin w_d3 = SEG_C; w_d2 = SEG_R; end
      endcase
      w_en = {w_vis_nxt, w_vis_nxt, 2'b00};
    end else begin
      w_d3 = {1'b0, w_p1_nxt[7:4]};
      w_d2 = {1'b0, w_p1_nxt[3:0]};
      w_d1 = {1'b0, w_p2_nxt[7:4]};
      w_d0 = {1'b0, w_p2_nxt[3:0]};
      w_en = {(w_p1_nxt[7:4] != 4'd0), 1'b1, (w_p2_nxt[7:4] != 4'd0), 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= SCORE;
      r_res   <= RES_P1;
      r_hold  <= '0;
      r_d3    <= SEG_BLANK;
      r_d2    <= SEG_BLANK;
      r_d1    <= SEG_BLANK;
      r_d0    <= SEG_BLANK;
      r_en    <= 4'b0101;
      r_msg   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_res   <= w_res_nxt;
      r_hold  <= w_hold_nxt;
      r_d3    <= w_d3;
      r_d2    <= w_d2;
      r_d1    <= w_d1;
      r_d0    <= w_d0;
      r_en    <= w_en;
      r_msg   <= (w_state_nxt == MSG);
    end
  end

  assign dig3_num   = r_d3;
  assign dig2_num   = r_d2;
  assign dig1_num   = r_d1;
  assign dig0_num   = r_d0;
  assign dig_en     = r_en;
  assign msg_active = r_msg;

endmodule

// File: tb/tb_scoreboard_ctrl.sv
// Directed bench for scoreboard_ctrl with MSG_CYCLES=8, BLINK_CYCLES=2.
module tb_scoreboard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, win_p1, win_p2, draw, clr_scores;
  logic [4:0] dig3_num, dig2_num, dig1_num, dig0_num;
  logic [3:0] dig_en;
  logic       msg_active;

  int n_chk  = 0;
  int n_pass = 0;

  scoreboard_ctrl #(.MSG_CYCLES(8), .BLINK_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .win_p1(win_p1), .win_p2(win_p2), .draw(draw),
    .clr_scores(clr_scores), .dig3_num(dig3_num), .dig2_num(dig2_num),
    .dig1_num(dig1_num), .dig0_num(dig0_num), .dig_en(dig_en), .msg_active(msg_active)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_view(input string tag, input int d3, input int d2, input int d1,
                            input int d0, input int en, input int ma);
    chk({tag, ".dig3"}, dig3_num, d3);
    chk({tag, ".dig2"}, dig2_num, d2);
    chk({tag, ".dig1"}, dig1_num, d1);
    chk({tag, ".dig0"}, dig0_num, d0);
    chk({tag, ".en"},   dig_en, en);
    chk({tag, ".msg"},  msg_active, ma);
  endtask

  initial begin
    int exp_hi;
    rst_n = 1'b0; win_p1 = 1'b0; win_p2 = 1'b0; draw = 1'b0; clr_scores = 1'b0;
    tick(2);
    check_view("in_reset", 0, 0, 0, 0, 4'b0101, 0);
    rst_n = 1'b1;
    tick();
    check_view("after_reset", 0, 0, 0, 0, 4'b0101, 0);

    // P1 win: message for exactly 8 clocks, blink pattern if enabled
    win_p1 = 1'b1; tick(); win_p1 = 1'b0;
    check_view("p1_msg", 11, 1, 0, 0, 4'b1100, 1);
    for (int i = 0; i < 8; i++) begin
`ifdef BLINK_EN
      exp_hi = ((i / 2) % 2 == 0) ? 3 : 0;
`else
      exp_hi = 3;
`endif
      chk($sformatf("blink%0d", i), dig_en[3:2], exp_hi);
      chk($sformatf("msg_hold%0d", i), msg_active, 1);
      tick();
    end
    check_view("p1_score", 0, 1, 0, 0, 4'b0101, 0);

    // 99 back-to-back P2 wins, then wrap on the 100th
    for (int i = 0; i < 99; i++) begin
      win_p2 = 1'b1; tick();
    end
    win_p2 = 1'b0;
    check_view("p2_99_msg", 11, 2, 0, 0, 4'b1100, 1);
    tick(8);
    check_view("p2_99", 0, 1, 9, 9, 4'b0111, 0);
    win_p2 = 1'b1; tick(); win_p2 = 1'b0;
    check_view("p2_wrap_msg", 11, 2, 0, 0, 4'b1100, 1);
    tick(8);
    check_view("p2_wrap", 0, 1, 0, 0, 4'b0101, 0);

    // Simultaneous win_p1 + draw, then a draw restarting the message
    win_p1 = 1'b1; draw = 1'b1; tick(); win_p1 = 1'b0; draw = 1'b0;
    check_view("prio_msg", 11, 1, 0, 0, 4'b1100, 1);
    tick(5);
    draw = 1'b1; tick(); draw = 1'b0;
    check_view("draw_msg", 10, 12, 0, 0, 4'b1100, 1);
    tick(7);
    chk("restart_hold", msg_active, 1);
    chk("restart_d3", dig3_num, 10);
    tick();
    check_view("after_draw", 0, 2, 0, 0, 4'b0101, 0);

    // Build P2 score 3, then clr_scores against a same-cycle P2 win
    for (int i = 0; i < 3; i++) begin
      win_p2 = 1'b1; tick(); win_p2 = 1'b0; tick(8);
    end
    check_view("p2_three", 0, 2, 0, 3, 4'b0101, 0);
    clr_scores = 1'b1; win_p2 = 1'b1; tick(); clr_scores = 1'b0; win_p2 = 1'b0;
    check_view("clr_msg", 11, 2, 0, 0, 4'b1100, 1);
    tick(8);
    check_view("clr_score", 0, 0, 0, 0, 4'b0101, 0);

    // Reset in the middle of a message
    win_p1 = 1'b1; tick(); win_p1 = 1'b0;
    chk("pre_abort_msg", msg_active, 1);
    tick(3);
    rst_n = 1'b0; tick();
    check_view("abort", 0, 0, 0, 0, 4'b0101, 0);
    rst_n = 1'b1; tick(9);
    check_view("post_abort", 0, 0, 0, 0, 4'b0101, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
